// File: rtl/stopwatch_disp_mux.sv
// Stopwatch display scanner: five time-multiplexed 7-segment digits
// (tenths, s units, s tens, min units, min tens). It is fed from a
// per-frame digit snapshot, inserts an anti-ghost blank window at the
// start of each slot and can suppress leading zeros.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   en           display enable (1 = drive digits)
//   blank_lz     leading-zero blanking enable
//   dig_ds       tenths digit (4 bit)
//   dig_s1       seconds units digit (4 bit)
//   dig_s2       seconds tens digit (3 bit)
//   dig_m1       minutes units digit (4 bit)
//   dig_m2       minutes tens digit (3 bit)
//   seg_n        segments g..a (bit0 = a), active-low
//   dp_n         decimal point, active-low
//   an_n         digit enables, active-low (bit0 = ds ... bit4 = m2)
//   frame_start  one-cycle pulse after each snapshot capture
module stopwatch_disp_mux #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       blank_lz,
    input  logic [3:0] dig_ds,
    input  logic [3:0] dig_s1,
    input  logic [2:0] dig_s2,
    input  logic [3:0] dig_m1,
    input  logic [2:0] dig_m2,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [4:0] an_n,
    output logic       frame_start
);

    localparam int unsigned CNT_W    = $clog2(SCAN_DIV);
    localparam logic [2:0]  IDX_LAST = 3'd4;
    localparam logic [6:0]  SEG_DASH = 7'h40;

    // Active-high gfedcba pattern; any code above 9 renders as a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] pat;
        pat = SEG_DASH;
        case (code)
            4'd0: pat = 7'h3F;
            4'd1: pat = 7'h06;
            4'd2: pat = 7'h5B;
            4'd3: pat = 7'h4F;
            4'd4: pat = 7'h66;
            4'd5: pat = 7'h6D;
            4'd6: pat = 7'h7D;
            4'd7: pat = 7'h07;
            4'd8: pat = 7'h7F;
            4'd9: pat = 7'h6F;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

    // 3-bit digits use 7 as their dash code; remap it to a dash code of the 4-bit decoder.
    function automatic logic [3:0] widen3(input logic [2:0] d);
        return (d == 3'd7) ? 4'hF : {1'b0, d};
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       ds_q, s1_q, m1_q;
    logic [2:0]       s2_q, m2_q;
    logic [6:0]       seg_n_q, seg_n_d;
    logic [4:0]       an_n_q, an_n_d;
    logic             dp_n_q, dp_n_d;
    logic             fs_q, fs_d;
    logic             tick, capture;

    // Prescaler, digit index and frame capture strobe.
    always_comb begin
        tick    = (cnt_q == CNT_W'(SCAN_DIV - 1));
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
        capture = tick && (idx_q == IDX_LAST);
        fs_d    = capture;
    end

    // Output decode from the current slot state; registered below.
    always_comb begin
        logic [3:0] code;
        logic       z_m2, z_m1, z_s2, blanked, show;
        code = ds_q;
        case (idx_q)
            3'd0:    code = ds_q;
            3'd1:    code = s1_q;
            3'd2:    code = widen3(s2_q);
            3'd3:    code = m1_q;
            3'd4:    code = widen3(m2_q);
            default: code = ds_q;
        endcase
        z_m2    = (m2_q == 3'd0);
        z_m1    = z_m2 && (m1_q == 4'd0);
        z_s2    = z_m1 && (s2_q == 3'd0);
        blanked = blank_lz && (((idx_q == 3'd4) && z_m2) ||
                               ((idx_q == 3'd3) && z_m1) ||
                               ((idx_q == 3'd2) && z_s2));
        show    = en && (cnt_q >= CNT_W'(BLANK_CYC)) && !blanked;

        an_n_d  = 5'h1F;
        seg_n_d = 7'h7F;
        dp_n_d  = 1'b1;
        if (show) begin
            an_n_d  = ~(5'b00001 << idx_q);
            seg_n_d = ~seg_decode(code);
            dp_n_d  = !((idx_q == 3'd1) || (idx_q == 3'd3));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= IDX_LAST;
            ds_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            m1_q    <= '0;
            m2_q    <= '0;
            an_n_q  <= 5'h1F;
            seg_n_q <= 7'h7F;
            dp_n_q  <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (capture) begin
                ds_q <= dig_ds;
                s1_q <= dig_s1;
                s2_q <= dig_s2;
                m1_q <= dig_m1;
                m2_q <= dig_m2;
            end
            an_n_q  <= an_n_d;
            seg_n_q <= seg_n_d;
            dp_n_q  <= dp_n_d;
            fs_q    <= fs_d;
        end
    end

    assign seg_n       = seg_n_q;
    assign dp_n        = dp_n_q;
    assign an_n        = an_n_q;
    assign frame_start = fs_q;

endmodule

// File: doc/stopwatch_disp_mux.md
STOPWATCH_DISP_MUX -- requirements
Module: stopwatch_disp_mux

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit slot (1 ms at 50 MHz); legal range >= 4.
REQ-002 SHALL have parameter BLANK_CYC, default 500, anti-ghost blank cycles at the start of each slot; legal range 0 to SCAN_DIV-1.
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  display enable, 1 = driving.
REQ-006 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-007 SHALL have ports dig_ds[3:0], dig_s1[3:0], dig_s2[2:0], dig_m1[3:0], dig_m2[2:0], all inputs, carrying the stopwatch tenths, s units, s tens, min units and min tens digits.
REQ-008 SHALL have port seg_n  output  7  segments g..a (bit0 = a), active-low.
REQ-009 SHALL have port dp_n  output  1  decimal point, active-low.
REQ-010 SHALL have port an_n  output  5  digit enables, active-low; bit0 = ds, bit1 = s1, bit2 = s2, bit3 = m1, bit4 = m2.
REQ-011 SHALL have port frame_start  output  1  one-cycle pulse marking a new digit snapshot.

Function
REQ-012 SHALL run prescaler cnt 0..SCAN_DIV-1, wrapping to 0; tick = (cnt == SCAN_DIV-1); cnt runs regardless of en.
REQ-013 SHALL advance digit index idx on each tick as 0,1,2,3,4,0,...; 4 wraps to 0.
REQ-014 SHALL, at the tick edge loading idx=0, capture all five digit inputs into a snapshot register; displayed values SHALL come only from the snapshot, so no tearing within a frame.
REQ-015 SHALL assert frame_start for exactly one clk, in the cycle after the snapshot capture edge.
REQ-016 SHALL register all outputs from (cnt, idx, snapshot, en, blank_lz), giving exactly one clk of latency.
REQ-017 SHALL drive an_n = 11111 while cnt < BLANK_CYC; otherwise only bit idx SHALL be low, unless that digit is blanked.
REQ-018 SHALL decode active-high gfedcba, with seg_n being its inverse: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
REQ-019 SHALL display codes 10-15 on 4-bit digits, and 7 on 3-bit digits, as a dash (g only, seg_n = 0111111).
REQ-020 SHALL drive dp_n = 0 only when idx = 1 (s1) or idx = 3 (m1) and that digit is displayed.
REQ-021 SHALL, when blank_lz = 1, blank digits from the snapshot as follows: m2 blanked if m2 == 0; m1 blanked if m2 == 0 and m1 == 0; s2 blanked if m2, m1 and s2 are all 0. ds and s1 are never blanked.
REQ-022 SHALL, for a blanked digit, hold an_n all-1, seg_n = 1111111 and dp_n = 1 for that slot.
REQ-023 SHALL, when en = 0, drive an_n = 11111, seg_n = 1111111 and dp_n = 1 one clk later; prescaler, idx, snapshot and frame_start are unaffected.
REQ-024 SHALL ignore digit input changes between captures, including a change in the same cycle as the capture edge (the value sampled at that edge wins).

Reset
REQ-025 SHALL, on rst, immediately set: cnt = 0, idx = 4, snapshot = 0, an_n = 11111, seg_n = 1111111, dp_n = 1, frame_start = 0.
REQ-026 SHALL take the first snapshot SCAN_DIV cycles after rst deassertion, when idx goes 4->0.
REQ-027 SHALL abort the current frame on rst asserted mid-scan, with no partial digit output after assertion.

Verification (SCAN_DIV = 8, BLANK_CYC = 2)
REQ-028 SHALL cover: release rst with inputs 0,0,0,0,0 -> frame_start pulses in the cycle after the 8th edge after release, then every 40 clk; an_n stays 11111 for 2 cycles of each slot, then steps 11110, 11101, 11011, 10111, 01111.
REQ-029 SHALL cover: ds=7, s1=3, s2=5, m1=2, m2=1, blank_lz=0 -> s1 slot shows seg_n=0110000 with dp_n=0; m1 slot shows seg_n=0100100 with dp_n=0; ds slot shows seg_n=1111000 with dp_n=1.
REQ-030 SHALL cover: m2=0, m1=0, s2=0, s1=4, ds=9, blank_lz=1 -> m2, m1 and s2 slots have an_n = 11111; s1 shows 4 with dp_n=0; then set m1=1 -> m1 displayed from the next frame only.
REQ-031 SHALL cover: change s1 from 3 to 6 mid-frame -> s1 still shows 3 until after the next frame_start; ds=12 -> dash.
REQ-032 SHALL cover: en deasserted for 10 clk mid-slot, then rst pulsed mid-frame -> all outputs inactive, and the frame_start period remains 40 clk relative to the preceding frame_start across the en gap; after rst, all REQ-025 values hold within the same cycle and the scan restarts per REQ-026.
